step_sequencer: RTL
===================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter N_STEPS, default 6, number of visible steps (2..32).
REQ-002 Parameter CNT_W, default 16, width of the instruction counter.
REQ-003 Parameter IDX_W, default $clog2(N_STEPS+1), width of the binary step index (derived, not overridden).
REQ-004 clk  in  1  sequencer clock, rising-edge.
REQ-005 reset  in  1  system reset, asynchronous, active-high.
REQ-006 run_en  in  1  1 = sequencer may advance; 0 = hold.
REQ-007 stall  in  1  1 = hold the current step this cycle (memory or I/O wait).
REQ-008 finish  in  1  instruction completes early; the next advance returns to step 1.
REQ-009 dbg_mode  in  1  1 = single-step mode.
REQ-010 dbg_step  in  1  single-cycle pulse granting one advance in dbg_mode.
REQ-011 step  out  N_STEPS  one-hot step vector; bit N_STEPS-1 = step 1, bit 0 = step N_STEPS; all-zero in step 0.
REQ-012 step_idx  out  IDX_W  binary step number, 0..N_STEPS.
REQ-013 last_step  out  1  high while in step N_STEPS.
REQ-014 restart  out  1  one-cycle pulse during the first cycle of step 1 when entered from any step >= 1.
REQ-015 instr_count  out  CNT_W  number of completed instructions, modulo 2^CNT_W.

Function
REQ-016 adv = run_en & ~stall & (~dbg_mode | dbg_step); no state changes when adv=0.
REQ-017 Step 0 is the reset state; when adv=1 in step 0, the next step is step 1, finish is ignored, and restart is not asserted.
REQ-018 Step k, 1 <= k < N_STEPS: when adv=1 and finish=0, the next step is k+1.
REQ-019 Step k, 1 <= k <= N_STEPS: when adv=1 and (finish=1 or k=N_STEPS), the next step is step 1; restart is asserted the following cycle and instr_count increments by 1.
REQ-020 Step 0 is never re-entered except through reset.
REQ-021 Priority order: reset > stall/run_en/dbg gating > finish > normal advance.
REQ-022 finish or dbg_step with adv=0 has no effect and is not remembered.
REQ-023 Exactly one transition occurs per adv cycle, including in dbg_mode with dbg_step held high (one advance per cycle).
REQ-024 All outputs are registered; a transition becomes visible one clk edge after the adv cycle.
REQ-025 step, step_idx and last_step are mutually consistent in every cycle; step is one-hot or all-zero.
REQ-026 instr_count wraps from 2^CNT_W-1 to 0 without any flag.

Reset
REQ-027 While reset is high: step=0, step_idx=0, last_step=0, restart=0, instr_count=0, asynchronously.
REQ-028 Reset asserted mid-instruction abandons that instruction and does not increment instr_count.
REQ-029 First possible advance occurs on the first rising clk edge after reset deasserts.

Structure
REQ-030 Shared package step_seq_pkg holds the default N_STEPS, CNT_W and the step-0 encoding constant; IDX_W is derived locally.
REQ-031 The block is a single module with no sub-module; the step register is held as a binary step_idx, and step is decoded from it into a registered one-hot.

Verification (N_STEPS=6, CNT_W=4)
REQ-032 Reset then run_en=1 for 14 cycles -> step_idx 1,2,3,4,5,6,1,2,...; restart high at cycles 7 and 13; instr_count=2.
REQ-033 stall=1 for 3 cycles while in step 3 -> step_idx stays 3 for 4 cycles total, then goes to 4.
REQ-034 finish=1 in step 4 with adv=1 -> next step_idx=1, restart=1, instr_count+1; finish=1 in step 0 -> step_idx=1, restart=0.
REQ-035 dbg_mode=1 with dbg_step pulsed at cycles 2, 5 and 9 -> step_idx 1, 2, 3 at cycles 3, 6 and 10, holding in between.
REQ-036 reset asserted asynchronously mid-step 5 -> all outputs 0 immediately, without waiting for a clk edge; 17 full instructions -> instr_count wraps to 1.

Source files
------------

// File: rtl/step_seq_pkg.sv
// Shared constants for the instruction step sequencer: default geometry and
// the encoding of the idle step 0.
package step_seq_pkg;

  localparam int unsigned NStepsDefault = 6;
  localparam int unsigned CntWDefault   = 16;
  localparam int unsigned StepZero      = 0;

endpackage

// File: rtl/step_sequencer.sv
// Instruction step sequencer: walks steps 1..N_STEPS under run/stall/debug
// gating, restarts early on finish, and counts completed instructions.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int unsigned N_STEPS = NStepsDefault,
  parameter int unsigned CNT_W   = CntWDefault,
  parameter int unsigned IDX_W   = $clog2(N_STEPS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_en,
  input  logic               stall,
  input  logic               finish,
  input  logic               dbg_mode,
  input  logic               dbg_step,
  output logic [N_STEPS-1:0] step,
  output logic [IDX_W-1:0]   step_idx,
  output logic               last_step,
  output logic               restart,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [IDX_W-1:0] IdxZero = IDX_W'(StepZero);
  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(N_STEPS);

  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_STEPS-1:0] step_q, step_d;
  logic               last_q, last_d;
  logic               restart_q, restart_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv;

  always_comb begin
    adv       = run_en & ~stall & (~dbg_mode | dbg_step);
    idx_d     = idx_q;
    restart_d = 1'b0;
    cnt_d     = cnt_q;

    if (adv) begin
      if (idx_q == IdxZero) begin
        // Leaving reset state: finish is meaningless here and no instruction completes.
        idx_d = IdxOne;
      end else if (finish || (idx_q == IdxLast)) begin
        idx_d     = IdxOne;
        restart_d = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
      end else begin
        idx_d = idx_q + IdxOne;
      end
    end

    // Bit N_STEPS-1 is step 1, bit 0 is step N_STEPS; step 0 decodes to all-zero.
    step_d = '0;
    for (int unsigned i = 0; i < N_STEPS; i++) begin
      step_d[i] = (idx_d == IDX_W'(N_STEPS - i));
    end
    last_d = (idx_d == IdxLast);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q     <= IdxZero;
      step_q    <= '0;
      last_q    <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      step_q    <= step_d;
      last_q    <= last_d;
      restart_q <= restart_d;
      cnt_q     <= cnt_d;
    end
  end

  assign step        = step_q;
  assign step_idx    = idx_q;
  assign last_step   = last_q;
  assign restart     = restart_q;
  assign instr_count = cnt_q;

endmodule
